pipe_fetch_queue: RTL and testbench

- Decoupled instruction-fetch unit that sits directly upstream of the IF/ID instruction register.
- Issues single-outstanding requests to a variable-latency instruction memory and buffers returned instructions, each with its PC+4, in a small FIFO.
- Presents the FIFO head to the ID side with a valid/ready handshake.
- Supports pipeline stall (ready low) and branch/jump redirect with flush of stale and in-flight fetches.

---
 rtl/pipe_fetch_queue.sv | 151 +++++++++++++++
 tb/tb_pipe_fetch_queue.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_fetch_queue.sv
// Purpose: decoupled instruction fetch with a single outstanding imem request and a DEPTH-entry {inst, pc+4} queue.
// Latency: zero-wait memory gives the head entry one cycle after the request; sustained 1 instruction/cycle.
// Backpressure: id_ready low holds the head; new requests stop while full, and an issued request holds until ack.
module pipe_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          PTRW     = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            redirect,
  input  logic [31:0]     redirect_pc,
  output logic            imem_req,
  output logic [31:0]     imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  input  logic            id_ready,
  output logic            inst_valid,
  output logic [31:0]     inst,
  output logic [31:0]     inst_pc4,
  output logic [PTRW:0]   count
);

  typedef enum logic [1:0] {ST_REQ, ST_WAIT, ST_DROP} state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
  } entry_t;

  localparam logic [PTRW:0] FULL_CNT = (PTRW+1)'(DEPTH);

  state_t          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     pending_pc_q, pending_pc_d;
  entry_t          fifo_q [DEPTH];
  logic [PTRW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTRW:0]   count_q, count_d;

  logic   req_raw;
  logic   push, pop, flush;
  entry_t head;

  // Request is only opened from REQ when a slot is free; once open it holds
  // until ack. The address always comes from fetch_pc, which in DROP still
  // holds the stale address of the request being drained.
  always_comb begin
    req_raw   = (state_q == ST_REQ) ? (count_q < FULL_CNT) : 1'b1;
    imem_req  = req_raw & ~reset;
    imem_addr = fetch_pc_q;
  end

  // Fetch FSM: redirect wins, flushing the queue and either retargeting
  // immediately or parking the target until the stale request returns.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    push         = 1'b0;
    pop          = 1'b0;
    flush        = 1'b0;
    if (redirect) begin
      flush = 1'b1;
      if (!req_raw || imem_ack) begin
        fetch_pc_d = redirect_pc;
        state_d    = ST_REQ;
      end else begin
        pending_pc_d = redirect_pc;
        state_d      = ST_DROP;
      end
    end else begin
      pop = inst_valid & id_ready;
      case (state_q)
        ST_REQ: begin
          if (req_raw && imem_ack) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end else if (req_raw) begin
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_ack) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = ST_REQ;
          end
        end
        ST_DROP: begin
          if (imem_ack) begin
            fetch_pc_d = pending_pc_q;
            state_d    = ST_REQ;
          end
        end
        default: state_d = ST_REQ;
      endcase
    end
  end

  // Occupancy: simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    if (flush)             count_d = '0;
    else if (push && !pop) count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  // FSM and fetch address registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_REQ;
      fetch_pc_q   <= RESET_PC;
      pending_pc_q <= RESET_PC;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
    end
  end

  // Queue storage and pointers; a flush snaps the read pointer to the write pointer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (flush) begin
        rd_ptr_q <= wr_ptr_q;
      end else begin
        if (push) begin
          fifo_q[wr_ptr_q] <= '{inst: imem_rdata, pc4: fetch_pc_q + 32'd4};
          wr_ptr_q         <= wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Head presentation, zeroed while empty.
  always_comb begin
    head       = fifo_q[rd_ptr_q];
    inst_valid = (count_q != '0);
    inst       = inst_valid ? head.inst : 32'h0;
    inst_pc4   = inst_valid ? head.pc4  : 32'h0;
    count      = count_q;
  end

endmodule

// File: tb/tb_pipe_fetch_queue.sv
// Directed bench for pipe_fetch_queue with a variable-latency memory model.
// Memory acks after 'lat' cycles of a held request; data is a function of address.
module tb_pipe_fetch_queue;

  logic        clock, reset, redirect, imem_req, imem_ack, id_ready, inst_valid;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, inst, inst_pc4;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;
  int lat    = 1;
  int wcnt   = 0;

  pipe_fetch_queue #(.DEPTH(4), .PTRW(2), .RESET_PC(32'h0000_0000)) dut (
    .clock(clock), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .id_ready(id_ready), .inst_valid(inst_valid),
    .inst(inst), .inst_pc4(inst_pc4), .count(count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign imem_ack   = imem_req && (wcnt == lat - 1);
  assign imem_rdata = (imem_addr == 32'h0) ? 32'h2001_0005 : {16'hA5A5, imem_addr[15:0]};

  always @(posedge clock) begin
    if (reset)                     wcnt <= 0;
    else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
    else                           wcnt <= 0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1;
    tick();
    tick();
    #1;
    chk("rst_req",   {31'b0, imem_req},   32'd0);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst",  inst,                32'd0);
    chk("rst_pc4",   inst_pc4,            32'd0);
    chk("rst_count", {29'b0, count},      32'd0);
    chk("rst_addr",  imem_addr,           32'h0);

    // Zero-wait memory, ready high
    reset = 1'b0; #1;
    chk("t1_req0",  {31'b0, imem_req}, 32'd1);
    chk("t1_addr0", imem_addr,          32'h0);
    tick();
    chk("t1_valid", {31'b0, inst_valid}, 32'd1);
    chk("t1_inst",  inst,                32'h2001_0005);
    chk("t1_pc4a",  inst_pc4,            32'd4);
    chk("t1_addr4", imem_addr,           32'd4);
    tick();
    chk("t1_addr8", imem_addr, 32'd8);
    chk("t1_pc4b",  inst_pc4,  32'd8);
    chk("t1_inst8", inst,      32'hA5A5_0004);
    tick();
    chk("t1_addr12", imem_addr,      32'd12);
    chk("t1_cnt",    {29'b0, count}, 32'd1);

    // Stall until full, then drain in order
    id_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) tick();
    chk("t2_cnt_full", {29'b0, count},    32'd4);
    chk("t2_req_off",  {31'b0, imem_req}, 32'd0);
    chk("t2_addr",     imem_addr,         32'd16);
    id_ready = 1'b1; #1;
    chk("t2_pop4", inst_pc4, 32'd4);
    tick();
    chk("t2_pop8",  inst_pc4,          32'd8);
    chk("t2_req",   {31'b0, imem_req}, 32'd1);
    chk("t2_addr16", imem_addr,        32'd16);
    tick();
    chk("t2_pop12", inst_pc4,       32'd12);
    chk("t2_cnt3",  {29'b0, count}, 32'd3);
    chk("t2_addr20", imem_addr,     32'd20);
    tick();
    chk("t2_pop16", inst_pc4, 32'd16);

    // 3-cycle memory latency, ready high
    lat = 3;
    do_reset();
    tick(); tick(); tick(); tick(); tick(); tick();
    chk("t3_c6_addr", imem_addr,      32'd8);
    chk("t3_c6_cnt",  {29'b0, count}, 32'd1);
    tick();
    chk("t3_c7_addr", imem_addr,         32'd8);
    chk("t3_c7_req",  {31'b0, imem_req}, 32'd1);
    chk("t3_c7_cnt",  {29'b0, count},    32'd0);
    tick();
    chk("t3_c8_addr", imem_addr,      32'd8);
    chk("t3_c8_cnt",  {29'b0, count}, 32'd0);
    tick();
    chk("t3_c9_cnt",  {29'b0, count}, 32'd1);
    chk("t3_c9_pc4",  inst_pc4,       32'd12);
    chk("t3_c9_addr", imem_addr,      32'd12);

    // Redirect with a request in flight -> DROP
    id_ready = 1'b0;
    do_reset();
    tick(); tick(); tick(); tick(); tick(); tick();
    chk("t4_pre_cnt",  {29'b0, count}, 32'd2);
    chk("t4_pre_addr", imem_addr,      32'd8);
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    redirect = 1'b0; #1;
    chk("t4_flush_cnt", {29'b0, count},    32'd0);
    chk("t4_flush_vld", {31'b0, inst_valid}, 32'd0);
    chk("t4_hold_addr", imem_addr,         32'd8);
    chk("t4_hold_req",  {31'b0, imem_req}, 32'd1);
    tick();
    chk("t4_c8_addr", imem_addr, 32'd8);
    tick();
    chk("t4_new_addr", imem_addr,      32'h100);
    chk("t4_drop_cnt", {29'b0, count}, 32'd0);
    tick(); tick(); tick();
    chk("t4_vld",  {31'b0, inst_valid}, 32'd1);
    chk("t4_pc4",  inst_pc4,            32'h104);

    // Redirect coinciding with ack, ready high, count 2
    tick(); tick(); tick();
    chk("t5_pre_cnt", {29'b0, count}, 32'd2);
    lat = 1; id_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0; #1;
    chk("t5_cnt",  {29'b0, count},    32'd0);
    chk("t5_addr", imem_addr,         32'h200);
    chk("t5_req",  {31'b0, imem_req}, 32'd1);
    tick();
    chk("t5_pc4", inst_pc4,       32'h204);
    chk("t5_cnt1", {29'b0, count}, 32'd1);

    // Redirect into DROP, second redirect overrides, then reset mid-WAIT
    lat = 3; redirect = 1'b1; redirect_pc = 32'h0000_0280;
    tick();
    redirect_pc = 32'h0000_0300; #1;
    chk("t6_drop_addr", imem_addr,      32'h204);
    chk("t6_drop_cnt",  {29'b0, count}, 32'd0);
    tick();
    redirect = 1'b0;
    tick();
    chk("t6_resume", imem_addr, 32'h300);
    tick();
    reset = 1'b1; #1;
    chk("t6_rst_req",  {31'b0, imem_req},   32'd0);
    chk("t6_rst_vld",  {31'b0, inst_valid}, 32'd0);
    chk("t6_rst_cnt",  {29'b0, count},      32'd0);
    chk("t6_rst_addr", imem_addr,           32'h0);
    tick();
    reset = 1'b0; #1;
    chk("t6_rel_req",  {31'b0, imem_req}, 32'd1);
    chk("t6_rel_addr", imem_addr,         32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
